// File: rtl/jtag_boundary_scan_chain.sv
// Boundary-scan register chain: input, output and output-enable cells with
// update latches, driving the output pads from the latches in EXTEST mode.
module jtag_boundary_scan_chain #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4
) (
    input  logic             tck,
    input  logic             trst,
    input  logic             bsr_tdi,
    input  logic             bsr_capture,
    input  logic             bsr_shift,
    input  logic             bsr_update,
    input  logic             bsr_mode,
    output logic             bsr_tdo,
    input  logic [N_IN-1:0]  pad_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    input  logic             core_oe,
    output logic [N_OUT-1:0] pad_out,
    output logic             pad_oe
);

    localparam int L = N_IN + N_OUT + 1;

    logic [L-1:0]     r_sr;
    logic [L-1:0]     r_upd;
    logic [N_OUT-1:0] w_upd_out;
    logic             w_upd_oe;

    // Capture has priority over shift; the chain moves toward sr[0] (bsr_tdo).
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_sr <= '0;
        end else if (bsr_capture) begin
            r_sr <= {core_oe, core_out, pad_in};
        end else if (bsr_shift) begin
            r_sr <= {bsr_tdi, r_sr[L-1:1]};
        end
    end

    // Update latches take the pre-edge chain contents regardless of capture/shift.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_upd <= '0;
        end else if (bsr_update) begin
            r_upd <= r_sr;
        end
    end

    assign w_upd_out = r_upd[N_IN+N_OUT-1:N_IN];
    assign w_upd_oe  = r_upd[L-1];

    assign bsr_tdo = r_sr[0];
    assign core_in = pad_in;
    assign pad_out = bsr_mode ? w_upd_out : core_out;
    assign pad_oe  = bsr_mode ? w_upd_oe  : core_oe;

endmodule

// File: tb/tb_jtag_boundary_scan_chain.sv
// Bench for jtag_boundary_scan_chain: vector table, hand-written corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_jtag_boundary_scan_chain;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int L     = N_IN + N_OUT + 1;

    logic             tck;
    logic             trst;
    logic             bsr_tdi;
    logic             bsr_capture;
    logic             bsr_shift;
    logic             bsr_update;
    logic             bsr_mode;
    logic             bsr_tdo;
    logic [N_IN-1:0]  pad_in;
    logic [N_IN-1:0]  core_in;
    logic [N_OUT-1:0] core_out;
    logic             core_oe;
    logic [N_OUT-1:0] pad_out;
    logic             pad_oe;

    int total;
    int bad;

    jtag_boundary_scan_chain #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .tck         (tck),
        .trst        (trst),
        .bsr_tdi     (bsr_tdi),
        .bsr_capture (bsr_capture),
        .bsr_shift   (bsr_shift),
        .bsr_update  (bsr_update),
        .bsr_mode    (bsr_mode),
        .bsr_tdo     (bsr_tdo),
        .pad_in      (pad_in),
        .core_in     (core_in),
        .core_out    (core_out),
        .core_oe     (core_oe),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: chain held as a queue with element 0 nearest bsr_tdo.
    bit m_sr[$];
    bit m_upd[L];

    function automatic void model_reset();
        m_sr.delete();
        for (int k = 0; k < L; k++) begin
            m_sr.push_back(1'b0);
            m_upd[k] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        bit pre[$];
        pre = m_sr;
        if (bsr_capture) begin
            m_sr.delete();
            for (int k = 0; k < N_IN; k++)  m_sr.push_back(pad_in[k]);
            for (int k = 0; k < N_OUT; k++) m_sr.push_back(core_out[k]);
            m_sr.push_back(core_oe);
        end else if (bsr_shift) begin
            void'(m_sr.pop_front());
            m_sr.push_back(bsr_tdi);
        end
        if (bsr_update) begin
            for (int k = 0; k < L; k++) m_upd[k] = pre[k];
        end
    endfunction

    function automatic logic [N_OUT-1:0] model_pad_out();
        logic [N_OUT-1:0] v;
        for (int j = 0; j < N_OUT; j++) v[j] = bsr_mode ? m_upd[N_IN+j] : core_out[j];
        return v;
    endfunction

    function automatic logic model_pad_oe();
        return bsr_mode ? m_upd[L-1] : core_oe;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit cap, input bit shf, input bit upd, input bit tdi);
        bsr_capture = cap;
        bsr_shift   = shf;
        bsr_update  = upd;
        bsr_tdi     = tdi;
        @(posedge tck);
        model_edge();
        #1;
    endtask

    typedef struct {
        bit         comb;
        bit         cap;
        bit         shf;
        bit         upd;
        bit         tdi;
        bit         mode;
        logic [3:0] pin;
        logic [3:0] cout;
        bit         coe;
        bit         e_tdo;
        logic [3:0] e_pout;
        bit         e_poe;
    } vec_t;

    function automatic vec_t mk(bit comb, bit cap, bit shf, bit upd, bit tdi, bit mode,
                                logic [3:0] pin, logic [3:0] cout, bit coe,
                                bit e_tdo, logic [3:0] e_pout, bit e_poe);
        vec_t v;
        v.comb = comb; v.cap = cap; v.shf = shf; v.upd = upd; v.tdi = tdi; v.mode = mode;
        v.pin = pin; v.cout = cout; v.coe = coe;
        v.e_tdo = e_tdo; v.e_pout = e_pout; v.e_poe = e_poe;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [8:0] unload_exp;
        logic [8:0] load_bits;
        total = 0;
        bad   = 0;

        // Capture {oe=1, out=0110, in=1010} then unload; then load 9 bits and EXTEST.
        unload_exp = 9'b101101010;   // bit k = tdo after k-th edge
        load_bits  = 9'b110010000;   // bit k = k-th bit shifted in
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'b1010, 4'b0110, 1, unload_exp[0], 4'b0110, 1));
        for (int k = 1; k < 9; k++)
            tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4'b1010, 4'b0110, 1, unload_exp[k], 4'b0110, 1));
        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(0, 0, 1, 0, load_bits[k], 0, 4'b1010, 4'b0110, 1, 0, 4'b0110, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 4'b1010, 4'b0110, 1, 0, 4'b1001, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1010, 4'b0110, 0, 0, 4'b0110, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4'b1010, 4'b0110, 0, 0, 4'b1001, 1));

        // Reset with EXTEST selected: pads must be released.
        trst = 1'b0; bsr_tdi = 0; bsr_capture = 0; bsr_shift = 0; bsr_update = 0;
        bsr_mode = 1'b1; pad_in = 4'b1111; core_out = 4'b1111; core_oe = 1'b1;
        #2;
        trst = 1'b1;
        model_reset();
        #1;
        chk("rst_tdo", bsr_tdo, 0);
        chk("rst_pad_out", pad_out, 0);
        chk("rst_pad_oe", pad_oe, 0);
        @(posedge tck); #1;
        trst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step(0, 0, 0, 0);
            chk("idle_tdo", bsr_tdo, 0);
            chk("idle_pad_out", pad_out, 0);
            chk("idle_pad_oe", pad_oe, 0);
        end

        for (int r = 0; r < tbl.size(); r++) begin
            bsr_mode = tbl[r].mode;
            pad_in   = tbl[r].pin;
            core_out = tbl[r].cout;
            core_oe  = tbl[r].coe;
            if (tbl[r].comb) begin
                #1;
            end else begin
                step(tbl[r].cap, tbl[r].shf, tbl[r].upd, tbl[r].tdi);
            end
            chk($sformatf("vec%0d_tdo", r), bsr_tdo, tbl[r].e_tdo);
            chk($sformatf("vec%0d_pad_out", r), pad_out, tbl[r].e_pout);
            chk($sformatf("vec%0d_pad_oe", r), pad_oe, tbl[r].e_poe);
        end

        // Capture beats shift; update alongside shift latches the pre-shift chain.
        bsr_mode = 1'b1; pad_in = 4'b0001; core_out = 4'b1010; core_oe = 1'b0;
        step(1, 1, 0, 0);
        chk("capshf_tdo", bsr_tdo, 1);
        step(0, 1, 1, 1);
        chk("updshf_tdo", bsr_tdo, 0);
        chk("updshf_pad_out", pad_out, 4'b1010);
        chk("updshf_pad_oe", pad_oe, 0);
        step(0, 0, 1, 0);
        chk("upd_after_pad_out", pad_out, 4'b0101);
        chk("upd_after_pad_oe", pad_oe, 1);

        // Reset partway through loading all-ones discards the pattern.
        for (int k = 0; k < 5; k++) step(0, 1, 0, 1);
        bsr_shift = 1'b0;
        trst = 1'b1;
        model_reset();
        @(posedge tck); #1;
        trst = 1'b0;
        chk("midrst_pad_out", pad_out, 0);
        step(0, 0, 1, 0);
        chk("midrst_upd_tdo", bsr_tdo, 0);
        chk("midrst_upd_pad_out", pad_out, 0);
        chk("midrst_upd_pad_oe", pad_oe, 0);

        // Randomized traffic; first stretch is pass-through while shifting.
        for (int c = 0; c < 120; c++) begin
            pad_in   = 4'($urandom);
            core_out = 4'($urandom);
            core_oe  = 1'($urandom);
            bsr_mode = (c < 40) ? 1'b0 : 1'($urandom);
            if (c < 40)
                step(1'($urandom_range(0, 7) == 0), 1'b1, 1'($urandom), 1'($urandom));
            else
                step(1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                     1'($urandom));
            chk("rnd_tdo", bsr_tdo, m_sr[0]);
            chk("rnd_pad_out", pad_out, model_pad_out());
            chk("rnd_pad_oe", pad_oe, model_pad_oe());
            chk("rnd_core_in", core_in, pad_in);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
